usb_rw_responder: RTL
=====================

# usb_rw_responder

Device-side responder for the thumb-drive read/write sequence. The host read/write FSM sends OUT to endpoint 4 carrying a 16-bit address, then either OUT to endpoint 8 with 64-bit write data or IN from endpoint 8 to read data. This block decodes those transactions from the device protocol FSM, performs the word access on a backing memory through a req/ack port, and returns one handshake per token (ACK, NAK, STALL or DATA). NAK is used as the flow-control mechanism while memory is busy.

## Interface
Parameters:
- DEV_ADDR, 7'd5: device address this block answers to.
- ADDR_ENDP, 4'd4: endpoint that carries the address OUT.
- DATA_ENDP, 4'd8: endpoint for data OUT/IN.

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- tok_valid  input  1  one-cycle pulse: device protocol FSM decoded a complete transaction.
- tok_in  input  1  1 = IN token, 0 = OUT token with data.
- tok_addr  input  7  token device address.
- tok_endp  input  4  token endpoint.
- data_rx  input  64  OUT data payload; valid with tok_valid.
- data_rx_ok  input  1  OUT payload CRC good; ignored for IN.
- resp_valid  output  1  one-cycle pulse: response for the last token.
- resp_type  output  2  0 ACK, 1 NAK, 2 STALL, 3 DATA.
- data_tx  output  64  IN payload; valid when resp_type = DATA.
- mem_req  output  1  memory request; held until mem_ack.
- mem_we  output  1  1 = write, 0 = read.
- mem_addr  output  16  word address.
- mem_wdata  output  64  write data.
- mem_rdata  input  64  read data; valid with mem_ack.
- mem_ack  input  1  one-cycle completion pulse.
- busy  output  1  high in WRITE or READ.
- stall_cnt  output  8  saturating count of STALL responses.

## Operation
- States: IDLE (no address), ADDR (address latched), WRITE, READ, RDATA (read word buffered).
- Token filter:
  - tok_addr != DEV_ADDR: ignored, no response.
  - OUT with data_rx_ok = 0: ignored, no response, and no state change.
- The token is evaluated against the state at the start of the cycle.
- OUT to ADDR_ENDP:
  - IDLE, ADDR or RDATA: latch data_rx[15:0] into addr_reg, discard any buffered read word, go to ADDR, respond ACK.
  - WRITE or READ: respond NAK, no change.
- OUT to DATA_ENDP:
  - ADDR: capture data_rx, assert mem_req with mem_we = 1 and mem_addr = addr_reg, go to WRITE, respond ACK.
  - WRITE or READ: respond NAK.
  - IDLE or RDATA: respond STALL.
- IN to DATA_ENDP:
  - ADDR: assert mem_req with mem_we = 0, go to READ, respond NAK.
  - READ or WRITE: respond NAK.
  - RDATA: respond DATA with data_tx = buffered word, go to IDLE.
  - IDLE: respond STALL.
- IN to ADDR_ENDP, or any other endpoint: respond STALL, no state change.
- mem_ack:
  - In WRITE: go to IDLE (the address is consumed).
  - In READ: buffer mem_rdata, go to RDATA.
  - Ignored in other states.
- If a token and mem_ack arrive in the same cycle, both are processed. The response comes from the pre-ack state, e.g. READ + IN returns NAK and the next state is RDATA.
- stall_cnt increments on every STALL response and saturates at 255.

## Timing
- Reset values: state IDLE, all outputs 0, addr_reg 0, buffer 0, stall_cnt 0.
- Reset mid-operation drops mem_req the next cycle. A mem_ack arriving later is ignored.
- Response latency: resp_valid is registered and pulses exactly 1 cycle after tok_valid. resp_type and data_tx are valid only in that cycle; data_tx is 0 otherwise.
- Back-to-back tok_valid on consecutive cycles is supported; each gets its own response.
- mem_req rises 1 cycle after the accepting token.
- mem_req, mem_we, mem_addr and mem_wdata stay stable until the cycle mem_ack is seen high. mem_req is low the following cycle.
- mem_ack in the same cycle mem_req first rises is legal.
- Minimum read turnaround: IN (NAK), mem_ack, IN (DATA). The second IN can be accepted 1 cycle after mem_ack.
- busy is registered and follows state.

## Test plan
- Write: OUT(5,4,data 0x1234), then OUT(5,8,0xDEADBEEF_CAFEF00D), mem_ack after 3 cycles -> ACK, ACK; one write request with mem_addr 0x1234 and that data; state returns to IDLE.
- Read with NAK retry: OUT(5,4,0x0042), IN(5,8), mem_ack with rdata 0x0123456789ABCDEF, IN(5,8) -> ACK, NAK, then DATA 0x0123456789ABCDEF; then a third IN -> STALL and stall_cnt = 1.
- Busy NAK: during WRITE, send OUT(5,4) and OUT(5,8) -> NAK, NAK; addr_reg stays unchanged.
- Filtering: a token to address 3 -> no resp_valid; OUT(5,4) with data_rx_ok = 0 -> no response and state stays IDLE.
- Simultaneous event: in READ, IN(5,8) in the same cycle as mem_ack -> NAK; the next IN -> DATA.
- Reset: assert rst while in WRITE with mem_req high -> mem_req 0 the next cycle; a late mem_ack is ignored; OUT(5,8) -> STALL.

Source files
------------

// File: rtl/usb_rw_responder.sv
// usb_rw_responder
// Device-side responder for the thumb-drive read/write sequence. An OUT to the
// address endpoint latches a 16-bit word address. An OUT to the data endpoint
// then writes a 64-bit word, or an IN from the data endpoint reads one. Every
// accepted token gets exactly one registered handshake. NAK throttles the host
// while the backing memory is busy.

module usb_rw_responder #(
    parameter logic [6:0] DEV_ADDR  = 7'd5,
    parameter logic [3:0] ADDR_ENDP = 4'd4,
    parameter logic [3:0] DATA_ENDP = 4'd8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tok_valid,
    input  logic        tok_in,
    input  logic [6:0]  tok_addr,
    input  logic [3:0]  tok_endp,
    input  logic [63:0] data_rx,
    input  logic        data_rx_ok,
    output logic        resp_valid,
    output logic [1:0]  resp_type,
    output logic [63:0] data_tx,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata,
    input  logic        mem_ack,
    output logic        busy,
    output logic [7:0]  stall_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_WRITE,
        ST_READ,
        ST_RDATA
    } state_e;

    localparam logic [1:0] RESP_ACK   = 2'd0;
    localparam logic [1:0] RESP_NAK   = 2'd1;
    localparam logic [1:0] RESP_STALL = 2'd2;
    localparam logic [1:0] RESP_DATA  = 2'd3;

    state_e      state_q, state_d, state_tok;
    logic [15:0] addr_reg_q, addr_reg_d;
    logic [63:0] rbuf_q, rbuf_d;
    logic        resp_valid_q, resp_valid_d;
    logic [1:0]  resp_type_q, resp_type_d;
    logic [63:0] data_tx_q, data_tx_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [63:0] mem_wdata_q, mem_wdata_d;
    logic        busy_q, busy_d;
    logic [7:0]  stall_cnt_q, stall_cnt_d;

    logic        tok_accept;
    logic        is_addr_out;
    logic        is_data_out;
    logic        is_data_in;
    logic        resp_fire;
    logic [1:0]  resp_code;
    logic        latch_addr;
    logic        start_write;
    logic        start_read;
    logic        send_data;
    logic        ack_write;
    logic        ack_read;

    // Classify the incoming token; foreign addresses and corrupt OUT payloads are dropped silently
    always_comb begin
        tok_accept  = tok_valid && (tok_addr == DEV_ADDR) && (tok_in || data_rx_ok);
        is_addr_out = !tok_in && (tok_endp == ADDR_ENDP);
        is_data_out = !tok_in && (tok_endp == DATA_ENDP);
        is_data_in  = tok_in && (tok_endp == DATA_ENDP);
    end

    // Decide the handshake and the token-driven state move, judged against the state at cycle start
    always_comb begin
        resp_fire   = 1'b0;
        resp_code   = RESP_ACK;
        state_tok   = state_q;
        latch_addr  = 1'b0;
        start_write = 1'b0;
        start_read  = 1'b0;
        send_data   = 1'b0;
        if (tok_accept) begin
            resp_fire = 1'b1;
            if (is_addr_out) begin
                case (state_q)
                    ST_IDLE, ST_ADDR, ST_RDATA: begin
                        latch_addr = 1'b1;
                        state_tok  = ST_ADDR;
                        resp_code  = RESP_ACK;
                    end
                    default: resp_code = RESP_NAK;
                endcase
            end else if (is_data_out) begin
                case (state_q)
                    ST_ADDR: begin
                        start_write = 1'b1;
                        state_tok   = ST_WRITE;
                        resp_code   = RESP_ACK;
                    end
                    ST_WRITE, ST_READ: resp_code = RESP_NAK;
                    default:           resp_code = RESP_STALL;
                endcase
            end else if (is_data_in) begin
                case (state_q)
                    ST_ADDR: begin
                        start_read = 1'b1;
                        state_tok  = ST_READ;
                        resp_code  = RESP_NAK;
                    end
                    ST_WRITE, ST_READ: resp_code = RESP_NAK;
                    ST_RDATA: begin
                        send_data = 1'b1;
                        state_tok = ST_IDLE;
                        resp_code = RESP_DATA;
                    end
                    default: resp_code = RESP_STALL;
                endcase
            end else begin
                resp_code = RESP_STALL;
            end
        end
    end

    // Fold in memory completion; tokens never move WRITE/READ, so the ack can override safely
    always_comb begin
        ack_write = mem_ack && (state_q == ST_WRITE);
        ack_read  = mem_ack && (state_q == ST_READ);
        state_d   = state_tok;
        if (ack_write) begin
            state_d = ST_IDLE;
        end else if (ack_read) begin
            state_d = ST_RDATA;
        end
    end

    // Address latch and read buffer; a new address throws away any unread word
    always_comb begin
        addr_reg_d = addr_reg_q;
        rbuf_d     = rbuf_q;
        if (latch_addr) begin
            addr_reg_d = data_rx[15:0];
        end
        if (latch_addr || send_data) begin
            rbuf_d = 64'd0;
        end
        if (ack_read) begin
            rbuf_d = mem_rdata;
        end
    end

    // Memory port: request is held for as long as an access is outstanding
    always_comb begin
        mem_req_d   = (state_d == ST_WRITE) || (state_d == ST_READ);
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (start_write) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = addr_reg_q;
            mem_wdata_d = data_rx;
        end else if (start_read) begin
            mem_we_d   = 1'b0;
            mem_addr_d = addr_reg_q;
        end
        busy_d = mem_req_d;
    end

    // Handshake outputs and the saturating STALL counter
    always_comb begin
        resp_valid_d = resp_fire;
        resp_type_d  = resp_fire ? resp_code : RESP_ACK;
        data_tx_d    = send_data ? rbuf_q : 64'd0;
        stall_cnt_d  = stall_cnt_q;
        if (resp_fire && (resp_code == RESP_STALL) && (stall_cnt_q != 8'hFF)) begin
            stall_cnt_d = stall_cnt_q + 8'd1;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            addr_reg_q   <= 16'd0;
            rbuf_q       <= 64'd0;
            resp_valid_q <= 1'b0;
            resp_type_q  <= RESP_ACK;
            data_tx_q    <= 64'd0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 16'd0;
            mem_wdata_q  <= 64'd0;
            busy_q       <= 1'b0;
            stall_cnt_q  <= 8'd0;
        end else begin
            state_q      <= state_d;
            addr_reg_q   <= addr_reg_d;
            rbuf_q       <= rbuf_d;
            resp_valid_q <= resp_valid_d;
            resp_type_q  <= resp_type_d;
            data_tx_q    <= data_tx_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            busy_q       <= busy_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_type  = resp_type_q;
    assign data_tx    = data_tx_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign busy       = busy_q;
    assign stall_cnt  = stall_cnt_q;

endmodule
